// File: rtl/axi_read_burst_ctrl.sv
// AXI4 read-channel responder for a synchronous single-port RAM: one AR burst at a time,
// FIXED/INCR/WRAP with narrow sizes, error responses for illegal or out-of-range beats.
module axi_read_burst_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic [ID_W-1:0]   s_arid,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic [ID_W-1:0]   s_rid,
  output logic              mem_ren,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned OFFS     = $clog2(DATA_W / 8);
  localparam logic [2:0]  MAX_SIZE = 3'(OFFS);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_WRAP  = 2'b10;
  localparam logic [1:0] BT_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic              arready_q, arready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              slverr_q, slverr_d;
  logic [7:0]        icnt_q, icnt_d;
  logic              idone_q, idone_d;
  logic              infl_q, infl_d;
  logic [1:0]        infl_resp_q, infl_resp_d;
  logic              infl_last_q, infl_last_d;

  logic [DATA_W-1:0] fdata_q [2];
  logic [1:0]        fresp_q [2];
  logic              flast_q [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] nsh, smask, bmask, beat_addr, word_idx;
  logic              beat_dec;
  logic [1:0]        beat_resp;
  logic              rvalid, pop, issue, head_last;
  logic [2:0]        occ;

  // WRAP: base is a multiple of B, so base + ((start-base+n*S) mod B) == base | ((start+n*S) & (B-1)).
  always_comb begin
    nsh   = ADDR_W'(icnt_q) << size_q;
    smask = (ADDR_W'(1) << size_q) - ADDR_W'(1);
    bmask = (ADDR_W'({1'b0, len_q} + 9'd1) << size_q) - ADDR_W'(1);
    case (burst_q)
      BT_FIXED: beat_addr = addr_q;
      BT_WRAP:  beat_addr = (addr_q & ~bmask) | ((addr_q + nsh) & bmask);
      default:  beat_addr = (icnt_q == 8'd0) ? addr_q : (addr_q & ~smask) + nsh;
    endcase
    word_idx  = beat_addr >> OFFS;
    beat_dec  = (word_idx >= ADDR_W'(MEM_DEPTH));
    beat_resp = slverr_q ? RESP_SLVERR : (beat_dec ? RESP_DECERR : RESP_OKAY);
  end

  // Credit: stored entries after this cycle's pop plus the in-flight slot must leave room.
  always_comb begin
    rvalid    = (cnt_q != 2'd0);
    pop       = rvalid & s_rready;
    head_last = rvalid & flast_q[rptr_q];
    occ       = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, infl_q};
    issue     = (state_q == BURST) & ~idone_q & (occ < 3'd2) & ~rst;
    mem_ren   = issue & (beat_resp == RESP_OKAY);
    mem_addr  = mem_ren ? word_idx[MEM_AW-1:0] : '0;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    id_d        = id_q;
    slverr_d    = slverr_q;
    icnt_d      = icnt_q;
    idone_d     = idone_q;
    infl_d      = issue;
    infl_resp_d = beat_resp;
    infl_last_d = (icnt_q == len_q);
    wptr_d      = wptr_q ^ infl_q;
    rptr_d      = rptr_q ^ pop;
    cnt_d       = cnt_q + {1'b0, infl_q} - {1'b0, pop};

    if (issue) begin
      if (icnt_q == len_q) idone_d = 1'b1;
      else                 icnt_d  = icnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (s_arvalid && arready_q) begin
          addr_d   = s_araddr;
          len_d    = s_arlen;
          size_d   = s_arsize;
          burst_d  = s_arburst;
          id_d     = s_arid;
          slverr_d = (s_arburst == BT_RSVD) || (s_arsize > MAX_SIZE) ||
                     ((s_arburst == BT_WRAP) &&
                      !(s_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
          icnt_d   = 8'd0;
          idone_d  = 1'b0;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      id_q        <= '0;
      slverr_q    <= 1'b0;
      icnt_q      <= '0;
      idone_q     <= 1'b0;
      infl_q      <= 1'b0;
      infl_resp_q <= '0;
      infl_last_q <= 1'b0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      id_q        <= id_d;
      slverr_q    <= slverr_d;
      icnt_q      <= icnt_d;
      idone_q     <= idone_d;
      infl_q      <= infl_d;
      infl_resp_q <= infl_resp_d;
      infl_last_q <= infl_last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Payload storage needs no reset: every output is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (infl_q) begin
      fdata_q[wptr_q] <= (infl_resp_q == RESP_OKAY) ? mem_rdata : '0;
      fresp_q[wptr_q] <= infl_resp_q;
      flast_q[wptr_q] <= infl_last_q;
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid;
  assign s_rdata   = rvalid ? fdata_q[rptr_q] : '0;
  assign s_rresp   = rvalid ? fresp_q[rptr_q] : '0;
  assign s_rlast   = head_last;
  assign s_rid     = id_q;

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Scoreboard bench for axi_read_burst_ctrl: directed bursts push expected beats and RAM
// addresses; a negedge monitor compares every R handshake and mem_ren against them.
module tb_axi_read_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [3:0]  s_arid;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        mem_ren;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;

  axi_read_burst_ctrl #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(1024)
  ) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic [3:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned addr_exp_q[$];
  int unsigned wq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned hs_cyc = 0;
  bit          lat_pend = 0, ar_pend = 0, stall_pend = 0, ignore = 0;
  int          outstanding = 0;
  logic [38:0] prev_pl = '0;

  function automatic logic [31:0] ram_val(input int unsigned w);
    return 32'hC0DE_0000 + w;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) mem_rdata <= ram_val({22'b0, mem_addr});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    logic  okpop;
    if (!rst && !ignore) begin
      if (ar_pend) begin
        chk("arready_after_last", s_arready, 1);
        ar_pend = 0;
      end
      if (s_arvalid && s_arready) begin
        hs_cyc   = cyc;
        lat_pend = 1;
      end
      if (s_rvalid && lat_pend) begin
        chk("first_rvalid_latency", cyc - hs_cyc, 3);
        lat_pend = 0;
      end
      if (stall_pend)
        chk("stall_stable", {s_rvalid, s_rdata, s_rresp, s_rlast, s_rid}, {1'b1, prev_pl});
      stall_pend = s_rvalid && !s_rready;
      prev_pl    = {s_rdata, s_rresp, s_rlast, s_rid};

      okpop = s_rvalid && s_rready && (s_rresp == 2'b00);
      if (mem_ren) begin
        chk("credit_no_overflow", (outstanding - int'(okpop)) < 2, 1);
        if (addr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_ren: got addr %0d expected no read", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, addr_exp_q.pop_front());
        end
      end
      outstanding = outstanding + int'(mem_ren) - int'(okpop);

      if (s_rvalid && s_rready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data %0h resp %0d expected no beat", s_rdata, s_rresp);
        end else begin
          b = exp_q.pop_front();
          chk("r_beat{data,resp,last,id}", {s_rdata, s_rresp, s_rlast, s_rid}, b);
        end
        if (s_rlast) ar_pend = 1;
      end
    end
  end

  task automatic exp_ok(input logic [3:0] id, input int unsigned w, input logic last);
    exp_q.push_back('{d: ram_val(w), r: 2'b00, l: last, id: id});
    addr_exp_q.push_back(w);
  endtask

  task automatic exp_err(input logic [3:0] id, input logic [1:0] resp, input logic last);
    exp_q.push_back('{d: 32'h0, r: resp, l: last, id: id});
  endtask

  task automatic exp_words(input logic [3:0] id, input int unsigned w[$]);
    for (int i = 0; i < w.size(); i++) exp_ok(id, w[i], i == w.size() - 1);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [3:0] id);
    bit ok = 0;
    s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bt; s_arid = id;
    s_arvalid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_arready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_handshake_timeout: got arready=0 expected 1");
    end
    @(posedge clk); #1;
    s_arvalid = 0;
  endtask

  task automatic wait_done(input string nm, input bit toggle);
    bit          ok = 0;
    logic [3:0]  pat = 4'b1001;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (toggle) s_rready = pat[3 - (k % 4)];
      if (exp_q.size() == 0 && s_arready && !s_rvalid) begin ok = 1; break; end
    end
    s_rready = 1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d beats left expected 0", nm, exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit quiet;
    rst = 1; s_arvalid = 0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arid = '0; s_rready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", s_arready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_payload{data,resp,last,id}", {s_rdata, s_rresp, s_rlast, s_rid}, 39'h0);
    chk("rst_mem{ren,addr}", {mem_ren, mem_addr}, 11'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk); chk("arready_reset_edge", s_arready, 0);
    @(negedge clk); chk("arready_after_reset", s_arready, 1);
    @(posedge clk); #1;

    wq = '{4, 5, 6, 7};     exp_words(4'h5, wq); send_ar(32'h10, 8'd3, 3'd2, 2'b01, 4'h5); wait_done("incr", 0);
    wq = '{14, 15, 12, 13}; exp_words(4'h6, wq); send_ar(32'h38, 8'd3, 3'd2, 2'b10, 4'h6); wait_done("wrap", 0);

    for (int i = 0; i < 3; i++) exp_err(4'h7, 2'b10, i == 2);
    send_ar(32'h38, 8'd2, 3'd2, 2'b10, 4'h7); wait_done("wrap_len2", 0);

    for (int i = 0; i < 8; i++) exp_ok(4'h3, 8, i == 7);
    send_ar(32'h20, 8'd7, 3'd2, 2'b00, 4'h3); wait_done("fixed", 0);

    wq.delete();
    for (int unsigned i = 0; i < 16; i++) wq.push_back(i);
    exp_words(4'h9, wq); send_ar(32'h0, 8'd15, 3'd2, 2'b01, 4'h9); wait_done("incr16_stall", 1);

    exp_ok(4'hB, 1022, 0); exp_ok(4'hB, 1023, 0);
    exp_err(4'hB, 2'b11, 0); exp_err(4'hB, 2'b11, 1);
    send_ar(32'hFF8, 8'd3, 3'd2, 2'b01, 4'hB); wait_done("decerr", 0);

    exp_err(4'h2, 2'b10, 0); exp_err(4'h2, 2'b10, 1);
    send_ar(32'h0, 8'd1, 3'd3, 2'b01, 4'h2); wait_done("oversize", 0);
    exp_err(4'h1, 2'b10, 1);
    send_ar(32'h0, 8'd0, 3'd2, 2'b11, 4'h1); wait_done("reserved", 0);

    wq = '{4, 5, 5}; exp_words(4'h4, wq); send_ar(32'h13, 8'd2, 3'd0, 2'b01, 4'h4); wait_done("narrow", 0);

    wq = '{32, 33}; exp_words(4'hC, wq);
    wq = '{40, 41, 42}; exp_words(4'hD, wq);
    send_ar(32'h80, 8'd1, 3'd2, 2'b01, 4'hC);
    send_ar(32'hA0, 8'd2, 3'd2, 2'b01, 4'hD);
    wait_done("back_to_back", 0);

    wq = '{16, 17, 18, 19, 20, 21, 22, 23}; exp_words(4'hE, wq);
    send_ar(32'h40, 8'd7, 3'd2, 2'b01, 4'hE);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() <= 6) break;
    end
    ignore = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); addr_exp_q.delete();
    outstanding = 0; lat_pend = 0; ar_pend = 0; stall_pend = 0;
    @(negedge clk);
    chk("midrst_{rvalid,mem_ren,arready,rlast}", {s_rvalid, mem_ren, s_arready, s_rlast}, 4'b0000);
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_rvalid || mem_ren) quiet = 0;
    end
    chk("midrst_no_stale_beats", quiet, 1);
    @(posedge clk); #1 ignore = 0;

    wq = '{4, 5}; exp_words(4'hA, wq); send_ar(32'h10, 8'd1, 3'd2, 2'b01, 4'hA); wait_done("after_rst", 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
